// File: rtl/cic_pkg.sv
// Shared constants and types for the PDM-to-PCM CIC decimator.
// Defaults give a 4-stage, 16:1 CIC with an 18-bit modular datapath and 17-bit output.
package cic_pkg;

  localparam int ORDER      = 4;
  localparam int LOG2_DECIM = 4;
  localparam int DECIM      = 2 ** LOG2_DECIM;
  localparam int ACC_W      = 2 + ORDER * LOG2_DECIM;
  localparam int OUT_W      = 17;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Output clamp limits: full-scale positive (+65536) cannot be represented in OUT_W bits.
  localparam acc_t SAT_MAX = acc_t'((2 ** (OUT_W - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (OUT_W - 1)));

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb section: out = in - previous accepted in.
// Arithmetic wraps at W bits, which is what keeps the CIC result exact.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  logic [W-1:0] dly_q, dly_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  always_comb begin
    dly_d       = dly_q;
    out_data_d  = out_data_q;
    out_valid_d = in_valid;
    if (clear) begin
      dly_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (in_valid) begin
      out_data_d = in_data - dly_q;
      dly_d      = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/cic_decimator.sv
// Hogenauer CIC decimator for one PDM channel: integrators at the PDM strobe rate,
// pipelined combs at the decimated rate, then clamp to OUT_W and warm-up gating.
module cic_decimator #(
  parameter int ORDER      = cic_pkg::ORDER,
  parameter int LOG2_DECIM = cic_pkg::LOG2_DECIM,
  parameter int OUT_W      = cic_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pdm_valid,
  input  logic             pdm_bit,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  localparam int DECIM = 2 ** LOG2_DECIM;
  localparam int ACC_W = 2 + ORDER * LOG2_DECIM;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  logic signed [ACC_W-1:0] integ_q [ORDER];
  logic signed [ACC_W-1:0] integ_d [ORDER];
  logic signed [ACC_W-1:0] x;
  logic [LOG2_DECIM-1:0]   count_q, count_d;
  logic                    dec_strobe_q, dec_strobe_d;
  logic [2:0]              warm_q, warm_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;

  logic [ORDER:0][ACC_W-1:0] comb_data;
  logic [ORDER:0]            comb_valid;
  logic signed [ACC_W-1:0]   comb_res;

  assign x = pdm_bit ? ACC_W'(1) : {ACC_W{1'b1}};

  // Each integrator adds the pre-update value of its predecessor (pipelined chain).
  always_comb begin
    integ_d      = integ_q;
    count_d      = count_q;
    dec_strobe_d = 1'b0;
    if (clear) begin
      for (int k = 0; k < ORDER; k++) integ_d[k] = '0;
      count_d = '0;
    end else if (pdm_valid) begin
      integ_d[0] = integ_q[0] + x;
      for (int k = 1; k < ORDER; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
      count_d      = count_q + LOG2_DECIM'(1);
      dec_strobe_d = (count_q == LOG2_DECIM'(DECIM - 1));
    end
  end

  assign comb_data[0]  = integ_q[ORDER-1];
  assign comb_valid[0] = dec_strobe_q;

  generate
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_comb
      cic_comb_stage #(.W(ACC_W)) u_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (comb_data[gi]),
        .in_valid  (comb_valid[gi]),
        .out_data  (comb_data[gi+1]),
        .out_valid (comb_valid[gi+1])
      );
    end
  endgenerate

  assign comb_res = comb_data[ORDER];

  // Results keep flowing into out_data during warm-up; only the pulse is withheld.
  always_comb begin
    warm_d      = warm_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      warm_d     = '0;
      out_data_d = '0;
    end else if (comb_valid[ORDER]) begin
      if (comb_res > SAT_MAX)      out_data_d = SAT_MAX[OUT_W-1:0];
      else if (comb_res < SAT_MIN) out_data_d = SAT_MIN[OUT_W-1:0];
      else                         out_data_d = comb_res[OUT_W-1:0];
      if (warm_q == 3'(ORDER)) out_valid_d = 1'b1;
      else                     warm_d      = warm_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
      count_q      <= '0;
      dec_strobe_q <= 1'b0;
      warm_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
      count_q      <= count_d;
      dec_strobe_q <= dec_strobe_d;
      warm_q       <= warm_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a sample-level CIC model queues expected pulses
// (data and cycle) when strobes are driven; a negedge monitor checks every cycle.
module tb_cic_decimator;
  import cic_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             pdm_valid = 1'b0;
  logic             pdm_bit = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;

  always #5 clk = ~clk;

  cic_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .pdm_valid (pdm_valid),
    .pdm_bit   (pdm_bit),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  typedef struct {
    int               cyc;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic             pat_on = 1'b0;
  logic             gap_on = 1'b0;
  logic [OUT_W-1:0] pat_exp = '0;
  int               last_pulse = -1;

  acc_t m_integ [ORDER];
  acc_t m_dly   [ORDER];
  int   m_cnt;
  int   m_warm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ORDER; k++) begin
      m_integ[k] = '0;
      m_dly[k]   = '0;
    end
    m_cnt  = 0;
    m_warm = 0;
  endtask

  task automatic flush_after(input int c);
    while (q.size() > 0 && q[q.size()-1].cyc > c) q.delete(q.size() - 1);
  endtask

  // Reference CIC at sample level; a completed frame yields a result 6 cycles later.
  task automatic model_strobe(input logic b);
    acc_t v, t;
    logic [OUT_W-1:0] s;
    for (int k = ORDER - 1; k > 0; k--) m_integ[k] = m_integ[k] + m_integ[k-1];
    m_integ[0] = m_integ[0] + (b ? acc_t'(1) : acc_t'(-1));
    if (m_cnt == DECIM - 1) begin
      m_cnt = 0;
      v = m_integ[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        t = v - m_dly[k];
        m_dly[k] = v;
        v = t;
      end
      if (v > acc_t'(65535))       s = 17'h0FFFF;
      else if (v < acc_t'(-65536)) s = 17'h10000;
      else                         s = v[OUT_W-1:0];
      if (m_warm == ORDER) q.push_back('{cyc: cyc + 6, data: s});
      else                 m_warm++;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic send(input logic b, input int gap);
    pdm_valid = 1'b1;
    pdm_bit   = b;
    model_strobe(b);
    @(posedge clk); #1;
    pdm_valid = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear(input logic with_valid, input logic b);
    clear     = 1'b1;
    pdm_valid = with_valid;
    pdm_bit   = b;
    model_reset();
    flush_after(cyc);
    @(posedge clk); #1;
    clear     = 1'b0;
    pdm_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    flush_after(cyc - 1);
    repeat (n) begin
      pdm_valid = 1'($urandom_range(0, 1));
      pdm_bit   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst_n     = 1'b1;
    pdm_valid = 1'b0;
  endtask

  task automatic start_phase(input logic pon, input logic [OUT_W-1:0] pexp, input logic gon);
    pat_on     = 1'b0;
    gap_on     = 1'b0;
    do_clear(1'b0, 1'b0);
    pat_on     = pon;
    pat_exp    = pexp;
    gap_on     = gon;
    last_pulse = -1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_v;
    if (!rst_n) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", {15'b0, out_data}, 32'd0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) q.delete(0);
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        e = q.pop_front();
        check("out_data", {15'b0, out_data}, {15'b0, e.data});
        if (pat_on) check("pattern", {15'b0, out_data}, {15'b0, pat_exp});
        if (gap_on && last_pulse >= 0) check("interval", cyc - last_pulse, 32'd64);
        last_pulse = cyc;
      end
    end
  end

  initial begin
    model_reset();
    // Reset held while strobes toggle: outputs must stay at zero.
    repeat (10) begin
      @(posedge clk); #1;
      pdm_valid = 1'($urandom_range(0, 1));
      pdm_bit   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    pdm_valid = 1'b0;
    pat_on     = 1'b1;
    pat_exp    = 17'h0FFFF;
    gap_on     = 1'b1;
    last_pulse = -1;
    repeat (160) send(1'b1, 4);

    start_phase(1'b1, 17'h10000, 1'b0);
    repeat (128) send(1'b0, 2);

    start_phase(1'b1, 17'h00000, 1'b0);
    for (int i = 0; i < 128; i++) send(1'(i % 2 == 0), 1);

    start_phase(1'b1, 17'h08000, 1'b0);
    for (int i = 0; i < 128; i++) send(1'(i % 4 != 3), 3);

    start_phase(1'b0, 17'h00000, 1'b0);
    repeat (320) send(1'($urandom_range(0, 1)), 1);

    // Mid-frame clear at strobe 40, then restart.
    repeat (40) send(1'($urandom_range(0, 1)), 1);
    do_clear(1'b0, 1'b0);
    repeat (120) send(1'($urandom_range(0, 1)), 1);

    // Clear together with a strobe: that sample is dropped.
    repeat (23) send(1'($urandom_range(0, 1)), 2);
    do_clear(1'b1, 1'b1);
    repeat (100) send(1'($urandom_range(0, 1)), 1);

    // Asynchronous reset pulse mid-frame.
    repeat (37) send(1'($urandom_range(0, 1)), 1);
    do_reset(2);
    repeat (100) send(1'($urandom_range(0, 1)), 1);

    repeat (20) @(posedge clk);
    #1;
    check("drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
